lc3b_mem_responder: RTL and testbench

- Memory-side responder for the LC-3b core memory port; it is the other end of the mem_read/mem_write/mem_resp handshake that the CPU drives.
- Holds a word-organised, byte-writable storage array and answers each request with a single-cycle mem_resp after a fixed latency.
- Used as the backing memory for core-level simulation and as the slave stub in front of future cache work.

---
 rtl/lc3b_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the LC-3b memory port: byte-writable word array, fixed-latency single-cycle mem_resp.
// Optional statistics counters (rd_count/wr_count) are enabled by defining LC3B_MEM_RESP_STATS_EN.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
`ifdef LC3B_MEM_RESP_STATS_EN
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
`endif
    output logic        proto_err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   resp_q, resp_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   perr_q, perr_d;

    logic                   op_wr_q, op_wr_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [1:0]             be_q, be_d;
    logic [15:0]            wdata_q, wdata_d;

    logic [15:0]            mem [DEPTH];

    logic                   req;
    logic                   rd_fire;
    logic [ADDR_BITS-1:0]   idx_in;
    logic [ADDR_BITS-1:0]   rd_idx;
    logic                   wr_lo;
    logic                   wr_hi;
    logic                   unused_addr_bits;

    // Upper address bits alias onto the array; bit 0 selects a byte within a word.
    assign idx_in           = mem_address[ADDR_BITS:1];
    assign unused_addr_bits = ^{mem_address[0], mem_address[15:1] >> ADDR_BITS};
    assign req              = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = 1'b0;
        perr_d  = perr_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rd_fire = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    op_wr_d = mem_write;
                    idx_d   = idx_in;
                    be_d    = mem_byte_enable;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_LOAD;
                    perr_d  = perr_q | (mem_read & mem_write);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        rd_fire = ~mem_write;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    // Initiator dropped the request: abandon it without a response.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    perr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        rd_fire = ~op_wr_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With a one-cycle latency the read is issued from the live address in IDLE.
    assign rd_idx  = (state_q == IDLE) ? idx_in : idx_q;
    assign rdata_d = rd_fire ? mem[rd_idx] : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        op_wr_q <= op_wr_d;
        idx_q   <= idx_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end

    // Writes land on the edge leaving RESP, using only the latched request.
    assign wr_lo = (state_q == RESP) & op_wr_q & be_q[0];
    assign wr_hi = (state_q == RESP) & op_wr_q & be_q[1];

    always_ff @(posedge clk) begin
        if (wr_lo) begin
            mem[idx_q][7:0] <= wdata_q[7:0];
        end
        if (wr_hi) begin
            mem[idx_q][15:8] <= wdata_q[15:8];
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;
    assign proto_err = perr_q;

`ifdef LC3B_MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        done;

    assign done = (state_q == RESP);

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (done && !op_wr_q && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (done && op_wr_q && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: a LATENCY=3 and a LATENCY=1 instance checked against a word-array model.
module tb_lc3b_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [1:0]  be    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdata [2];
    logic [1:0]  resp;
    logic [1:0]  perr;
`ifdef LC3B_MEM_RESP_STATS_EN
    logic [15:0] rdc [2];
    logic [15:0] wrc [2];
`endif

    lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(3)) dut0 (
        .clk(clk), .rst_n(rstn[0]),
        .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wdata[0]),
        .mem_resp(resp[0]), .mem_rdata(rdata[0]),
`ifdef LC3B_MEM_RESP_STATS_EN
        .rd_count(rdc[0]), .wr_count(wrc[0]),
`endif
        .proto_err(perr[0])
    );

    lc3b_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rstn[1]),
        .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wdata[1]),
        .mem_resp(resp[1]), .mem_rdata(rdata[1]),
`ifdef LC3B_MEM_RESP_STATS_EN
        .rd_count(rdc[1]), .wr_count(wrc[1]),
`endif
        .proto_err(perr[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one word array per instance, indexed by word address modulo depth.
    logic [15:0] mdl [2][1024];
    logic [15:0] last_rd [2];
    logic        mperr [2];
    int          ncr [2];
    int          ncw [2];

    typedef struct {
        bit          r;
        bit          w;
        logic [1:0]  m;
        logic [15:0] a;
        logic [15:0] dat;
        logic [15:0] exp_rd;
        bit          exp_pe;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % 1024;
    endfunction

    function automatic logic [15:0] model_expect(input int d, input bit w, input logic [15:0] a);
        return w ? last_rd[d] : mdl[d][widx(a)];
    endfunction

    task automatic model_apply(input int d, input bit r, input bit w, input logic [1:0] m,
                               input logic [15:0] a, input logic [15:0] dat);
        int i;
        i = widx(a);
        if (w) begin
            if (m[0]) mdl[d][i][7:0]  = dat[7:0];
            if (m[1]) mdl[d][i][15:8] = dat[15:8];
            ncw[d]++;
        end else begin
            last_rd[d] = mdl[d][i];
            ncr[d]++;
        end
        if (r && w) mperr[d] = 1'b1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xact(input int d, input bit r, input bit w, input logic [1:0] m,
                        input logic [15:0] a, input logic [15:0] dat,
                        output int lat, output logic [15:0] rv);
        rd[d] = r; wr[d] = w; be[d] = m; addr[d] = a; wdata[d] = dat;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp[d]) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
            if (n == 0) begin
                addr[d]  = 16'($urandom);
                wdata[d] = 16'($urandom);
                be[d]    = 2'($urandom);
            end
        end
        rv = rdata[d];
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(negedge clk);
        check("resp_one_cycle", 32'(resp[d]), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_checked(input string tag, input int d, input bit r, input bit w,
                               input logic [1:0] m, input logic [15:0] a, input logic [15:0] dat);
        int          lat;
        logic [15:0] rv;
        logic [15:0] exp;
        exp = model_expect(d, w, a);
        xact(d, r, w, m, a, dat, lat, rv);
        model_apply(d, r, w, m, a, dat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat(d)));
        check({tag, "_rdata"}, 32'(rv), 32'(exp));
        check({tag, "_perr"}, 32'(perr[d]), 32'(mperr[d]));
    endtask

    initial begin
        int          lat;
        int          gap;
        int          nresp;
        bit          got;
        logic [15:0] rv;

        rstn = 2'b00; rd = 2'b00; wr = 2'b00;
        for (int d = 0; d < 2; d++) begin
            be[d] = 2'b00; addr[d] = 16'h0000; wdata[d] = 16'h0000;
            last_rd[d] = 16'h0000; mperr[d] = 1'b0; ncr[d] = 0; ncw[d] = 0;
            for (int i = 0; i < 1024; i++) mdl[d][i] = 16'h0000;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_resp", 32'(resp[d]), 32'd0);
            check("reset_rdata", 32'(rdata[d]), 32'd0);
            check("reset_perr", 32'(perr[d]), 32'd0);
        end
        @(negedge clk);
        rstn = 2'b11;
        @(posedge clk); #1;

        tbl.push_back('{1'b0, 1'b1, 2'b11, 16'h0040, 16'h1234, 16'h0000, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h1234, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b11, 16'h0010, 16'hAAAA, 16'h1234, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b01, 16'h0010, 16'h5566, 16'h1234, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hAA66, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b00, 16'h0010, 16'h7777, 16'hAA66, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hAA66, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b10, 16'h0840, 16'h9999, 16'hAA66, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h9934, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b11, 16'h0002, 16'h1357, 16'h9934, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b11, 16'h0004, 16'h2468, 16'h9934, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2'b11, 16'h0020, 16'h1111, 16'h9934, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 2'b11, 16'h0008, 16'h0F0F, 16'h9934, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 2'b00, 16'h0008, 16'h0000, 16'h0F0F, 1'b1});

        foreach (tbl[k]) begin
            xact(0, tbl[k].r, tbl[k].w, tbl[k].m, tbl[k].a, tbl[k].dat, lat, rv);
            model_apply(0, tbl[k].r, tbl[k].w, tbl[k].m, tbl[k].a, tbl[k].dat);
            check($sformatf("vec%0d_lat", k), 32'(lat), 32'd3);
            check($sformatf("vec%0d_rdata", k), 32'(rv), 32'(tbl[k].exp_rd));
            check($sformatf("vec%0d_perr", k), 32'(perr[0]), 32'(tbl[k].exp_pe));
        end

        // Read held high across RESP: two back-to-back reads.
        rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0002;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (resp[0]) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("b2b_first_resp", 32'(got), 32'd1);
        check("b2b_first_data", 32'(rdata[0]), 32'h1357);
        @(posedge clk); #1;
        addr[0] = 16'h0004;
        gap = -1;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (resp[0]) begin gap = n; break; end
            @(posedge clk); #1;
        end
        check("b2b_gap", 32'(gap), 32'd4);
        check("b2b_second_data", 32'(rdata[0]), 32'h2468);
        @(posedge clk); #1;
        rd[0] = 1'b0;
        nresp = 0;
        repeat (6) begin @(negedge clk); if (resp[0]) nresp++; end
        check("b2b_no_extra_resp", 32'(nresp), 32'd0);
        last_rd[0] = 16'h2468; ncr[0] += 2;
        @(posedge clk); #1;

        // Read dropped during BUSY.
        rd[0] = 1'b1; addr[0] = 16'h0040;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        nresp = 0;
        repeat (6) begin @(negedge clk); if (resp[0]) nresp++; end
        check("abort_no_resp", 32'(nresp), 32'd0);
        check("abort_perr", 32'(perr[0]), 32'd1);
        check("abort_rdata_hold", 32'(rdata[0]), 32'h2468);
        @(posedge clk); #1;

        // Reset asserted while a write is in BUSY.
        wr[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'hBEEF; be[0] = 2'b11;
        @(posedge clk); #2;
        rstn[0] = 1'b0;
        #1;
        check("rst_mid_resp", 32'(resp[0]), 32'd0);
        check("rst_mid_rdata", 32'(rdata[0]), 32'd0);
        check("rst_mid_perr", 32'(perr[0]), 32'd0);
        wr[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn[0] = 1'b1;
        @(posedge clk); #1;
        last_rd[0] = 16'h0000; mperr[0] = 1'b0; ncr[0] = 0; ncw[0] = 0;
        run_checked("rst_old_value", 0, 1'b1, 1'b0, 2'b00, 16'h0020, 16'h0000);
        check("rst_old_value_exact", 32'(last_rd[0]), 32'h1111);

        // A fresh abort after reset must raise the flag again.
        rd[0] = 1'b1; addr[0] = 16'h0040;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort2_perr", 32'(perr[0]), 32'd1);
        mperr[0] = 1'b1;

        // LATENCY=1 instance with an aliased address.
        run_checked("alias_wr", 1, 1'b0, 1'b1, 2'b11, 16'h0800, 16'hC3C3);
        run_checked("alias_rd", 1, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000);
        check("alias_value", 32'(last_rd[1]), 32'hC3C3);

        for (int k = 0; k < 200; k++) begin
            int          d;
            int          op;
            bit          r;
            bit          w;
            logic [15:0] a;
            d  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 19));
            r  = (op == 0) || (op < 9);
            w  = (op == 0) || (op >= 9);
            a  = 16'($urandom);
            if (op[0]) a = {5'($urandom), 8'h00, 3'($urandom)};
            run_checked($sformatf("rnd%0d_d%0d", k, d), d, r, w, 2'($urandom), a, 16'($urandom));
        end

`ifdef LC3B_MEM_RESP_STATS_EN
        for (int d = 0; d < 2; d++) begin
            check("stats_rd_count", 32'(rdc[d]), 32'(ncr[d]));
            check("stats_wr_count", 32'(wrc[d]), 32'(ncw[d]));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
